// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the half-bridge dead-band stage.
// State encoding, default counter width and target-side codes.
package pwm_deadtime_pkg;

    localparam int DT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic TGT_HIGH = 1'b1;
    localparam logic TGT_LOW  = 1'b0;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead band and
// latched fault shutdown, fed by the registered PWM waveform.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwm_in,
    input  logic            en,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            in_dead,
    output logic            fault_latched
);

    localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

    state_t          state, state_nx;
    logic [DT_W-1:0] cnt, cnt_nx;
    logic            tgt, tgt_nx;
    logic            dt_zero;
    logic            side_nx;
    logic            load;

    assign dt_zero = (dead_time == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            cnt           <= '0;
            tgt           <= TGT_LOW;
            pwm_h         <= 1'b0;
            pwm_l         <= 1'b0;
            in_dead       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            tgt           <= tgt_nx;
            pwm_h         <= (state_nx == ST_HIGH);
            pwm_l         <= (state_nx == ST_LOW);
            in_dead       <= (state_nx == ST_DEAD);
            fault_latched <= (state_nx == ST_FAULT);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        side_nx  = pwm_in;
        load     = 1'b0;

        if (fault) begin
            state_nx = ST_FAULT;
            cnt_nx   = '0;
        end else if (state == ST_FAULT) begin
            if (fault_clr)
                state_nx = ST_OFF;
        end else if (!en) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_OFF:  load = 1'b1;
                ST_HIGH: load = !pwm_in;
                ST_LOW:  load = pwm_in;
                ST_DEAD: begin
                    // Target tracks the input; the count is never restarted.
                    tgt_nx = pwm_in;
                    if (cnt <= CNT_ONE)
                        state_nx = tgt ? ST_HIGH : ST_LOW;
                    else
                        cnt_nx = cnt - CNT_ONE;
                end
                default: state_nx = ST_OFF;
            endcase
        end

        if (load) begin
            if (dt_zero) begin
                state_nx = (side_nx == TGT_HIGH) ? ST_HIGH : ST_LOW;
            end else begin
                state_nx = ST_DEAD;
                cnt_nx   = dead_time;
                tgt_nx   = side_nx;
            end
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized bench for pwm_deadtime against a cycle-level
// behavioural model of the gate-driver rules.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_in;
    logic       en;
    logic [7:0] dead_time;
    logic       fault;
    logic       fault_clr;
    logic       pwm_h;
    logic       pwm_l;
    logic       in_dead;
    logic       fault_latched;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_OFF  = 0;
    localparam int M_DEAD = 1;
    localparam int M_HI   = 2;
    localparam int M_LO   = 3;
    localparam int M_FLT  = 4;

    int m_mode;
    int m_left;
    int m_tgt;

    always #5 clk = ~clk;

    pwm_deadtime #(.DT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .en           (en),
        .dead_time    (dead_time),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .in_dead      (in_dead),
        .fault_latched(fault_latched)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Start a switch toward side s: immediate with no dead band.
    task automatic m_switch(input int s);
        if (dead_time == 0) begin
            m_mode = s ? M_HI : M_LO;
        end else begin
            m_mode = M_DEAD;
            m_left = int'(dead_time);
            m_tgt  = s;
        end
    endtask

    task automatic m_edge();
        if (fault) begin
            m_mode = M_FLT;
        end else if (m_mode == M_FLT) begin
            if (fault_clr) m_mode = M_OFF;
        end else if (!en) begin
            m_mode = M_OFF;
        end else if (m_mode == M_OFF) begin
            m_switch(int'(pwm_in));
        end else if (m_mode == M_HI) begin
            if (!pwm_in) m_switch(0);
        end else if (m_mode == M_LO) begin
            if (pwm_in) m_switch(1);
        end else begin
            if (m_left <= 1) m_mode = (m_tgt != 0) ? M_HI : M_LO;
            else m_left = m_left - 1;
            m_tgt = int'(pwm_in);
        end
    endtask

    function automatic logic [3:0] m_out();
        return {m_mode == M_HI, m_mode == M_LO,
                m_mode == M_DEAD, m_mode == M_FLT};
    endfunction

    task automatic step(input logic p, input logic e, input logic f,
                        input logic fc, input logic [7:0] d);
        @(negedge clk);
        pwm_in    = p;
        en        = e;
        fault     = f;
        fault_clr = fc;
        dead_time = d;
        @(posedge clk);
        m_edge();
        #1;
        check("gates", {pwm_h, pwm_l, in_dead, fault_latched}, m_out());
        check("overlap", {3'b000, pwm_h & pwm_l}, 4'b0000);
    endtask

    initial begin
        logic p;
        int   seg;
        logic [7:0] dt;

        rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0;
        dead_time = 8'd0; fault = 1'b0; fault_clr = 1'b0;
        m_mode = M_OFF; m_left = 0; m_tgt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {pwm_h, pwm_l, in_dead, fault_latched}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // dead_time 4: start-up band, then high-to-low switch
        repeat (8)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        repeat (8)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        // dead_time 0 with a period-10 square wave
        for (int i = 0; i < 30; i++)
            step(((i / 5) % 2) == 0, 1'b1, 1'b0, 1'b0, 8'd0);
        // short low pulse inside a 6-cycle band
        repeat (4)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
        repeat (3)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
        repeat (8)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
        // fault while low, ineffective clear, then proper clear
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
        repeat (2)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        repeat (6)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        // dead_time changed from 8 to 2 mid-band
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        repeat (5)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        // enable dropped mid-band
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        repeat (2)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        repeat (2)  step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);

        // randomized traffic
        p  = 1'b0;
        dt = 8'd3;
        for (int n = 0; n < 300; n++) begin
            seg = $urandom_range(1, 14);
            p   = ~p;
            if ($urandom_range(0, 3) == 0) dt = 8'($urandom_range(0, 9));
            for (int k = 0; k < seg; k++)
                step(p, $urandom_range(0, 60) != 0,
                     $urandom_range(0, 120) == 0,
                     $urandom_range(0, 6) == 0, dt);
        end

        // asynchronous reset while high-side gate is on
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        check("high_before_rst", {3'b000, pwm_h}, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {pwm_h, pwm_l, in_dead, fault_latched}, 4'b0000);
        m_mode = M_OFF;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Output stage that sits directly downstream of top's pwm_out and drives a half-bridge.
- Converts the single PWM waveform into complementary high-side and low-side gate signals.
- Inserts a programmable dead band between the two gate signals and latches a fault shutdown.
- Same clock domain as pwm_out (registered upstream), so there is no input synchronizer.

Parameters:
DT_W, 8, width of dead_time and of the internal dead-band counter

Ports:
clk  input  1  system clock, same as top
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  PWM waveform, connected to top.pwm_out
en  input  1  stage enable; 0 forces both gates off
dead_time  input  DT_W  dead band length in clk cycles; 0 means no dead band
fault  input  1  synchronous active-high fault request (level)
fault_clr  input  1  single-cycle pulse that clears the latched fault
pwm_h  output  1  high-side gate, active-high, registered
pwm_l  output  1  low-side gate, active-high, registered
in_dead  output  1  1 while in DEAD state (both gates off pending a switch)
fault_latched  output  1  1 while in FAULT state

Behaviour:
- Reset: all outputs 0, state OFF, counter 0, tgt 0.
- Outputs are decoded from the state register and change only on clk edges.
  - pwm_h = (state==HIGH); pwm_l = (state==LOW).
  - pwm_h and pwm_l are never both 1 on any cycle.
- States: OFF, DEAD, HIGH, LOW, FAULT. DEAD carries a target bit tgt.
- Priority per edge, top item wins:
  1. fault=1: go to FAULT.
  2. en=0: go to OFF.
  3. Normal transitions below.
- OFF (en=1, no fault): load cnt=dead_time, tgt=pwm_in, go to DEAD.
  - If dead_time==0, go directly to HIGH when pwm_in=1, else LOW.
- HIGH: pwm_in=0 loads cnt=dead_time, tgt=0, go to DEAD. If dead_time==0, go straight to LOW.
- LOW: mirror of HIGH. pwm_in=1 loads cnt, tgt=1, go to DEAD, or straight to HIGH if dead_time==0.
- DEAD:
  - tgt follows pwm_in every cycle; cnt is NOT reloaded when tgt changes.
  - cnt<=1: go to the tgt state (HIGH if tgt=1, else LOW).
  - Otherwise cnt decrements.
- Timing:
  - pwm_in edge sampled at edge t: the active gate drops after edge t.
  - Both gates then stay 0 for exactly dead_time cycles; the new gate rises after edge t+dead_time.
  - With dead_time=0, the switch is one cycle after the sample with no dead cycle.
- Short pulses: a pwm_in pulse shorter than dead_time never reaches the opposite gate. The stage returns to the original side at the end of the count.
- dead_time is sampled only on load; a change mid-DEAD takes effect at the next load.
- FAULT: both gates 0, fault_latched=1.
  - Exit to OFF only on an edge with fault_clr=1 and fault=0; otherwise stay in FAULT.
  - en is ignored while in FAULT.
- en falling mid-DEAD: go to OFF on the next edge and abandon the count.
- Asynchronous reset mid-operation: outputs go to 0 immediately, independent of clk.

Decomposition:
- Package pwm_deadtime_pkg holds:
  - the state enum (OFF, DEAD, HIGH, LOW, FAULT)
  - DT_W default
  - encoding constants
- No sub-module; the down-counter is a few lines inside the FSM. The block is a single module.

Test Plan:
- Reset, then en=1, dead_time=4, pwm_in=1:
  - both gates 0 for 4 cycles (in_dead=1), then pwm_h=1.
  - pwm_in->0: pwm_h drops next edge, 4 dead cycles, then pwm_l=1.
- dead_time=0, 50% pwm_in with period 10:
  - pwm_h/pwm_l exact complements delayed 1 cycle, in_dead never 1.
- In HIGH with dead_time=6, pwm_in low pulse of 3 cycles:
  - pwm_l never asserts, pwm_h returns after 6 dead cycles.
  - Assert pwm_h&pwm_l==0 every cycle.
- fault=1 for one cycle while in LOW:
  - both gates 0 and fault_latched=1 from the next edge.
  - fault_clr with fault=1 has no effect.
  - fault_clr with fault=0: OFF, then DEAD on the following edge.
- dead_time changed from 8 to 2 mid-DEAD:
  - the current dead band still lasts 8 cycles.
  - the next transition uses 2.
- en=0 mid-DEAD, and rst_n pulsed asynchronously between edges while in HIGH:
  - OFF with both gates 0.
  - pwm_h falls with rst_n, not at a clock edge.
